otp_burn_seq: RTL and testbench
===============================

# otp_burn_seq

Program-memory burn sequencer. Sits between a host byte stream (I2C/SFR debug bridge) and the instruction-memory controller's SFR programming port. It holds the MCU, then programs a run of consecutive OTP bytes from an auto-incrementing start address. Each byte is optionally read back and retried, and the block reports progress and failures to status registers.

## Interface
Parameters:
- BIT_ADDR, 15, program-memory address width
- FIFO_DEPTH, 4, host byte FIFO depth (power of 2)
- PTR_W, 3, FIFO pointer width including wrap bit (log2(FIFO_DEPTH)+1)
- RETRY_MAX, 3, program attempts per byte before failure
- HOLD_WAIT, 6, cycles between raising hold and first memory request
- TMO_W, 11, ack watchdog width; timeout at all-ones

Ports:
- clk  in  1  clock
- srst  in  1  synchronous reset, active-high
- start  in  1  1T pulse; latches start_adr, byte_cnt, verify_en; ignored while busy
- start_adr  in  BIT_ADDR  first byte address
- byte_cnt  in  BIT_ADDR  bytes to program; 0 = no-op, done pulse only
- verify_en  in  1  enable read-back compare per byte
- abort  in  1  1T pulse; ends the job at the next safe point
- wr_vld / wr_rdy  in/out  1/1  host byte handshake; transfer when both high
- wr_dat  in  8  host data byte
- psofs  out  BIT_ADDR  address to controller
- psw  out  1  1T program request
- psr  out  1  read request, level until ack
- ack  in  1  1T completion from controller (its offset-increment strobe)
- rdat  in  8  read-back data, valid in the ack cycle of a read
- hold  out  1  MCU hold request
- busy  out  1  job active
- done  out  1  1T end-of-job pulse
- err  out  1  sticky, set on verify failure/timeout/abort, cleared by start
- err_adr  out  BIT_ADDR  address of first failure
- left  out  BIT_ADDR  bytes remaining

## Operation
- Reset values: all outputs 0; wr_rdy 0; FIFO empty; state IDLE.
- FIFO: depth FIFO_DEPTH, wrap-bit pointers. Full = pointers differ only in MSB; empty = equal. wr_rdy = busy & ~full & (pushed+queued < left); excess bytes are never accepted.
- States:
  - IDLE: on start, load adr/left/verify, clear err/err_adr/FIFO, go HOLD. byte_cnt==0 -> DONE directly.
  - HOLD: hold=1, count HOLD_WAIT cycles -> FETCH.
  - FETCH: if FIFO non-empty, pop into cur_dat, retry=0, go PGM. Abort pending -> DONE.
  - PGM: one-cycle psw=1, psofs=adr -> PGMW.
  - PGMW: wait ack -> RD if verify_en, else NEXT.
  - RD: psr=1 held until ack. On ack, compare rdat==cur_dat. Match -> NEXT. Mismatch with retry<RETRY_MAX-1 -> retry++ and PGM. Otherwise set err, latch err_adr (if first) -> DONE.
  - NEXT: adr++ (wraps modulo 2^BIT_ADDR), left--. left becomes 0 -> DONE, else FETCH.
  - DONE: done=1, hold=0, flush FIFO -> IDLE.
- Abort is latched as abort_pend. It takes effect only in FETCH or after an ack, never mid-request. It sets err and err_adr=adr.
- Watchdog: clears on entry to PGMW/RD and counts while waiting. At all-ones it drops psr, sets err and err_adr=adr, then DONE.
- Start while busy is ignored. Simultaneous start and abort in IDLE: start wins, abort dropped.
- srst mid-job: immediate return to reset values. No psw pulse is generated in the reset cycle.

## Timing
- hold rises the cycle after start. First psw at start+1+HOLD_WAIT+1 if the FIFO has data.
- psw is exactly 1T. psr is asserted the cycle after the PGM ack, and dropped the cycle after the read ack.
- Per-byte overhead beyond controller latency: 3 cycles (FETCH, PGM, NEXT), plus 1 for RD when verifying.
- done fires the cycle after the last NEXT. busy falls with done. err is valid when done is high.
- A FIFO push and pop in the same cycle are both honoured.

## Structure
- Shared package: state encodings, RETRY_MAX/HOLD_WAIT defaults, TMO_W.
- One sub-module, sync_fifo_wb (wrap-bit pointer FIFO, parameterised width/depth). The sequencer FSM, counters and watchdog stay in the top.

## Test plan
- start_adr=0x100, byte_cnt=3, verify off, bytes A5,5A,FF; ack 10 cycles after each psw -> psofs 0x100,0x101,0x102, three psw pulses, done, err=0, left=0.
- Verify on, rdat matches first try -> psw/psr alternate per byte, no retries, err=0.
- Verify on, rdat wrong twice then correct at 0x200 -> three psw at 0x200, err=0. Wrong three times -> err=1, err_adr=0x200, done, hold=0.
- ack never returns -> done 2047 cycles after psw, err=1, psr low.
- start_adr=0x7FFF, byte_cnt=2 -> second psofs=0x0000.
- abort during PGMW -> current ack completes, no further psw, done, err=1, err_adr=current address. srst mid-RD -> psr=0 and busy=0 next cycle.

Source files
------------

// File: rtl/otp_burn_seq_pkg.sv
// Shared definitions for the OTP burn sequencer: FSM encoding and default timing constants.
package otp_burn_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_FETCH,
        S_PGM,
        S_PGMW,
        S_RD,
        S_NEXT,
        S_DONE
    } state_t;

    localparam int RETRY_MAX_DEF = 3;
    localparam int HOLD_WAIT_DEF = 6;
    localparam int TMO_W_DEF     = 11;

endpackage

// File: rtl/otp_burn_seq_fifo.sv
// Wrap-bit pointer synchronous FIFO with show-ahead read data and a flush input.
module sync_fifo_wb #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int PTR_W = 3
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = PTR_W - 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wptr, rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[PTR_W-1] != rptr[PTR_W-1]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign dout  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + PTR_W'(1);
            if (pop && !empty)
                rptr <= rptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/otp_burn_seq.sv
// OTP burn sequencer: holds the MCU and programs a run of bytes from a host FIFO,
// with optional read-back verify, bounded retries, abort and an ack watchdog.
module otp_burn_seq
    import otp_burn_seq_pkg::*;
#(
    parameter int BIT_ADDR   = 15,
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 3,
    parameter int RETRY_MAX  = RETRY_MAX_DEF,
    parameter int HOLD_WAIT  = HOLD_WAIT_DEF,
    parameter int TMO_W      = TMO_W_DEF
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                start,
    input  logic [BIT_ADDR-1:0] start_adr,
    input  logic [BIT_ADDR-1:0] byte_cnt,
    input  logic                verify_en,
    input  logic                abort,
    input  logic                wr_vld,
    output logic                wr_rdy,
    input  logic [7:0]          wr_dat,
    output logic [BIT_ADDR-1:0] psofs,
    output logic                psw,
    output logic                psr,
    input  logic                ack,
    input  logic [7:0]          rdat,
    output logic                hold,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [BIT_ADDR-1:0] err_adr,
    output logic [BIT_ADDR-1:0] left
);
    localparam int HW_W = (HOLD_WAIT > 1) ? $clog2(HOLD_WAIT) : 1;
    localparam int RT_W = (RETRY_MAX > 1) ? $clog2(RETRY_MAX) : 1;

    state_t              state, state_nxt;
    logic [BIT_ADDR-1:0] adr, acc_left;
    logic                verify, abort_pend;
    logic [7:0]          cur_dat;
    logic [RT_W-1:0]     retry;
    logic [HW_W-1:0]     hcnt;
    logic [TMO_W-1:0]    wdog;
    logic                tmo;
    logic                push, pop, fifo_clr, set_err, retry_inc;
    logic [7:0]          fifo_dout;
    logic                full, empty;

    sync_fifo_wb #(.W(8), .DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_fifo (
        .clk   (clk),
        .srst  (srst),
        .clr   (fifo_clr),
        .push  (push),
        .din   (wr_dat),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    assign tmo    = &wdog;
    assign busy   = (state != S_IDLE) && (state != S_DONE);
    assign hold   = busy;
    assign done   = (state == S_DONE);
    assign psw    = (state == S_PGM) && !srst;
    assign psr    = (state == S_RD) && !srst;
    assign psofs  = adr;
    // acc_left tracks bytes still to be accepted, so the host can never overrun the job
    assign wr_rdy = busy && !full && (acc_left != '0);
    assign push   = wr_vld && wr_rdy;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        set_err   = 1'b0;
        retry_inc = 1'b0;
        fifo_clr  = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                fifo_clr  = 1'b1;
                state_nxt = (byte_cnt == '0) ? S_DONE : S_HOLD;
            end
            S_HOLD: if (hcnt == HW_W'(HOLD_WAIT - 1)) state_nxt = S_FETCH;
            S_FETCH: begin
                if (abort_pend) begin
                    set_err   = 1'b1;
                    state_nxt = S_DONE;
                end else if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = S_PGM;
                end
            end
            S_PGM: state_nxt = S_PGMW;
            S_PGMW: begin
                if (ack) begin
                    if (abort_pend) begin
                        set_err   = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = verify ? S_RD : S_NEXT;
                    end
                end else if (tmo) begin
                    set_err   = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_RD: begin
                if (ack) begin
                    if (abort_pend) begin
                        set_err   = 1'b1;
                        state_nxt = S_DONE;
                    end else if (rdat == cur_dat) begin
                        state_nxt = S_NEXT;
                    end else if (retry < RT_W'(RETRY_MAX - 1)) begin
                        retry_inc = 1'b1;
                        state_nxt = S_PGM;
                    end else begin
                        set_err   = 1'b1;
                        state_nxt = S_DONE;
                    end
                end else if (tmo) begin
                    set_err   = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_NEXT: state_nxt = (left == BIT_ADDR'(1)) ? S_DONE : S_FETCH;
            S_DONE: begin
                fifo_clr  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state      <= S_IDLE;
            adr        <= '0;
            left       <= '0;
            acc_left   <= '0;
            verify     <= 1'b0;
            abort_pend <= 1'b0;
            cur_dat    <= '0;
            retry      <= '0;
            hcnt       <= '0;
            wdog       <= '0;
            err        <= 1'b0;
            err_adr    <= '0;
        end else begin
            state <= state_nxt;

            if (state == S_IDLE && start) begin
                adr      <= start_adr;
                left     <= byte_cnt;
                acc_left <= byte_cnt;
                verify   <= verify_en;
                err      <= 1'b0;
                err_adr  <= '0;
            end
            if (push)
                acc_left <= acc_left - BIT_ADDR'(1);
            if (state == S_NEXT) begin
                adr  <= adr + BIT_ADDR'(1);
                left <= left - BIT_ADDR'(1);
            end

            hcnt <= (state == S_HOLD) ? hcnt + HW_W'(1) : '0;

            if (pop) begin
                cur_dat <= fifo_dout;
                retry   <= '0;
            end else if (retry_inc) begin
                retry <= retry + RT_W'(1);
            end

            // watchdog restarts on entry to each wait state
            if (state == S_PGM || (state == S_PGMW && ack))
                wdog <= '0;
            else if ((state == S_PGMW || state == S_RD) && !tmo)
                wdog <= wdog + TMO_W'(1);

            if (set_err) begin
                err <= 1'b1;
                if (!err)
                    err_adr <= adr;
            end

            // an abort arriving while idle (even alongside start) is dropped
            if (state == S_IDLE || state == S_DONE)
                abort_pend <= 1'b0;
            else if (abort)
                abort_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_otp_burn_seq.sv
// Bench for otp_burn_seq: table-driven jobs, hand-written corner sequences and random
// jobs checked against a per-byte reference model of the burn rules.
module tb_otp_burn_seq;
    localparam int RETRY = 3;

    logic        clk = 0, srst = 1, start = 0, verify_en = 0, abort = 0;
    logic        wr_vld = 0, ack = 0;
    logic [14:0] start_adr = '0, byte_cnt = '0;
    logic [7:0]  wr_dat = '0, rdat = '0;
    logic        wr_rdy, psw, psr, hold, busy, done, err;
    logic [14:0] psofs, err_adr, left;

    otp_burn_seq dut (
        .clk(clk), .srst(srst), .start(start), .start_adr(start_adr), .byte_cnt(byte_cnt),
        .verify_en(verify_en), .abort(abort), .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_dat(wr_dat),
        .psofs(psofs), .psw(psw), .psr(psr), .ack(ack), .rdat(rdat), .hold(hold), .busy(busy),
        .done(done), .err(err), .err_adr(err_adr), .left(left)
    );

    always #5 clk = ~clk;

    int compared = 0, mismatched = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // job context shared by responder, feeder and monitor
    int       job_adr, fail_adr, fail_cnt, ack_lat = 1;
    bit       ack_en = 1, job_over = 1, feeding = 0;
    logic [7:0] job_dat [16];
    int       feed_n, feed_gap, abort_dly, n_acc;
    int       got_adr[$];
    int       first_psw_cyc, start_cyc, done_cyc;
    bit       prev_psw = 0;
    int       r_done, r_err, r_eadr, r_left, r_busy, r_hold, r_psr, r_hold1;
    int       m_q[$];
    int       m_err, m_eadr, m_left;

    typedef struct {
        int adr; int cnt; bit ver; int fail_at; int fail_n;
        int exp_err; int exp_eadr; int exp_npsw; int exp_left;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string nm, input int got, input int exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int got, input int lo, input int hi);
        compared++;
        if (got < lo || got > hi) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, got, lo, hi);
        end
    endtask

    // Reference: each byte takes one program attempt, or with verify up to RETRY
    // attempts; a byte still wrong after RETRY reads ends the job with an error.
    task automatic model(input int adr, input int cnt, input bit ver, input int fail_at, input int fail_n);
        int a, tries;
        m_q.delete(); m_err = 0; m_eadr = 0; m_left = cnt;
        for (int i = 0; i < cnt; i++) begin
            a = (adr + i) % 32768;
            tries = 1;
            if (ver && i == fail_at) tries = (fail_n + 1 < RETRY) ? fail_n + 1 : RETRY;
            for (int t = 0; t < tries; t++) m_q.push_back(a);
            if (ver && i == fail_at && fail_n >= RETRY) begin
                m_err = 1; m_eadr = a;
                break;
            end
            m_left--;
        end
    endtask

    task automatic chk_seq();
        chk("npsw", got_adr.size(), m_q.size());
        for (int i = 0; i < m_q.size() && i < got_adr.size(); i++)
            chk("psofs", got_adr[i], m_q[i]);
    endtask

    // psw monitor: records addresses and insists each pulse is one cycle wide
    always @(negedge clk) begin
        if (psw) begin
            got_adr.push_back(int'(psofs));
            if (first_psw_cyc < 0) first_psw_cyc = cyc;
            chk("psw_1T", int'(prev_psw), 0);
        end
        prev_psw = psw;
    end

    // controller model: ack ack_lat cycles after psw or psr; read data may be corrupted
    initial begin
        bit skip, rd;
        int a, idx;
        skip = 0;
        forever begin
            if (!skip) @(negedge clk);
            skip = 0;
            if (ack_en && !srst && (psw || psr)) begin
                a  = int'(psofs);
                rd = psr;
                repeat (ack_lat) @(negedge clk);
                ack = 1;
                if (rd) begin
                    idx = (a - job_adr) & 32'h7fff;
                    rdat = (idx < 16) ? job_dat[idx] : 8'h00;
                    if (a == fail_adr && fail_cnt > 0) begin
                        rdat = rdat ^ 8'h3C;
                        fail_cnt--;
                    end
                end
                @(negedge clk);
                ack  = 0;
                skip = 1;
            end
        end
    end

    task automatic feed();
        bit took;
        for (int i = 0; i < feed_n && !job_over; i++) begin
            repeat ($urandom_range(0, feed_gap)) @(posedge clk);
            #1;
            wr_dat = job_dat[i];
            wr_vld = 1;
            took = 0;
            while (!took && !job_over) begin
                @(negedge clk);
                if (wr_rdy) took = 1;
            end
            if (took) begin
                @(posedge clk); #1;
                n_acc++;
            end
            wr_vld = 0;
        end
    endtask

    task automatic run_job(input int adr, input int cnt, input bit ver, input int fail_at,
                           input int fail_n, input int lat, input int adly, input int gap, input bit use_ack);
        job_adr = adr;
        for (int i = 0; i < 16; i++) job_dat[i] = 8'($urandom);
        fail_adr = (fail_at >= 0) ? (adr + fail_at) % 32768 : -1;
        fail_cnt = (fail_at >= 0) ? fail_n : 0;
        ack_lat = lat; ack_en = use_ack;
        feed_n = cnt + 2; feed_gap = gap; abort_dly = adly;
        got_adr.delete(); first_psw_cyc = -1; n_acc = 0; job_over = 0; feeding = 1;
        @(negedge clk);
        start = 1; start_adr = 15'(adr); byte_cnt = 15'(cnt); verify_en = ver;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 0;
        fork begin feed(); feeding = 0; end join_none
        if (abort_dly >= 0) fork
            begin
                int k;
                k = 0;
                while (got_adr.size() == 0 && !job_over && k < 5000) begin @(negedge clk); k++; end
                if (!job_over) begin
                    repeat (abort_dly) @(negedge clk);
                    abort = 1;
                    @(negedge clk);
                    abort = 0;
                end
            end
        join_none
        r_done = 0; r_hold1 = 0;
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            if (n == 0) r_hold1 = int'(hold);
            if (done) begin r_done = 1; break; end
        end
        if (!r_done) $display("FAIL done_wait: done not seen within 6000 cycles");
        done_cyc = cyc;
        r_err = int'(err); r_eadr = int'(err_adr); r_left = int'(left);
        r_busy = int'(busy); r_hold = int'(hold); r_psr = int'(psr);
        job_over = 1;
        for (int n = 0; n < 100 && feeding; n++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int adr, cnt, fat, fn, lat, gap;
        bit ver, seen;

        vecs[0] = '{adr:'h100,  cnt:3, ver:0, fail_at:-1, fail_n:0, exp_err:0, exp_eadr:0,     exp_npsw:3, exp_left:0};
        vecs[1] = '{adr:'h180,  cnt:3, ver:1, fail_at:-1, fail_n:0, exp_err:0, exp_eadr:0,     exp_npsw:3, exp_left:0};
        vecs[2] = '{adr:'h200,  cnt:1, ver:1, fail_at:0,  fail_n:2, exp_err:0, exp_eadr:0,     exp_npsw:3, exp_left:0};
        vecs[3] = '{adr:'h200,  cnt:1, ver:1, fail_at:0,  fail_n:3, exp_err:1, exp_eadr:'h200, exp_npsw:3, exp_left:1};
        vecs[4] = '{adr:'h7FFF, cnt:2, ver:0, fail_at:-1, fail_n:0, exp_err:0, exp_eadr:0,     exp_npsw:2, exp_left:0};
        vecs[5] = '{adr:'h300,  cnt:0, ver:0, fail_at:-1, fail_n:0, exp_err:0, exp_eadr:0,     exp_npsw:0, exp_left:0};
        vecs[6] = '{adr:'h400,  cnt:4, ver:1, fail_at:2,  fail_n:3, exp_err:1, exp_eadr:'h402, exp_npsw:5, exp_left:2};

        // reset state
        srst = 1;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);     chk("rst_hold", int'(hold), 0);
        chk("rst_done", int'(done), 0);     chk("rst_err", int'(err), 0);
        chk("rst_wr_rdy", int'(wr_rdy), 0); chk("rst_psw", int'(psw), 0);
        chk("rst_psr", int'(psr), 0);       chk("rst_psofs", int'(psofs), 0);
        chk("rst_left", int'(left), 0);     chk("rst_err_adr", int'(err_adr), 0);
        srst = 0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            model(vecs[i].adr, vecs[i].cnt, vecs[i].ver, vecs[i].fail_at, vecs[i].fail_n);
            run_job(vecs[i].adr, vecs[i].cnt, vecs[i].ver, vecs[i].fail_at, vecs[i].fail_n, 10, -1, 0, 1);
            chk("done", r_done, 1);
            chk("err", r_err, vecs[i].exp_err);
            chk("err_adr", r_eadr, vecs[i].exp_eadr);
            chk("left", r_left, vecs[i].exp_left);
            chk("npsw_tbl", got_adr.size(), vecs[i].exp_npsw);
            chk_seq();
            chk("busy_at_done", r_busy, 0);
            chk("hold_at_done", r_hold, 0);
            if (!vecs[i].exp_err) chk("accepted", n_acc, vecs[i].cnt);
            if (i == 0) begin
                chk("hold_rise", r_hold1, 1);
                chk("first_psw_lat", first_psw_cyc - start_cyc, 8);
            end
        end

        // watchdog: ack never returns
        run_job('h600, 1, 1, -1, 0, 10, -1, 0, 0);
        chk("tmo_done", r_done, 1);
        chk("tmo_err", r_err, 1);
        chk("tmo_err_adr", r_eadr, 'h600);
        chk("tmo_psr", r_psr, 0);
        chk_rng("tmo_delay", done_cyc - first_psw_cyc, 2045, 2051);

        // abort while waiting for the program ack
        run_job('h700, 3, 0, -1, 0, 10, 2, 0, 1);
        chk("abort_done", r_done, 1);
        chk("abort_err", r_err, 1);
        chk("abort_err_adr", r_eadr, 'h700);
        chk("abort_npsw", got_adr.size(), 1);

        // srst while a read is outstanding
        job_adr = 'h500; fail_cnt = 0; fail_adr = -1; ack_lat = 20; ack_en = 1;
        feed_n = 2; feed_gap = 0; n_acc = 0; job_over = 0; feeding = 1;
        @(negedge clk);
        start = 1; start_adr = 15'h500; byte_cnt = 15'd2; verify_en = 1;
        @(posedge clk); #1;
        start = 0;
        fork begin feed(); feeding = 0; end join_none
        seen = 0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (psr) seen = 1;
        end
        chk("rst_rd_psr_seen", int'(seen), 1);
        srst = 1;
        @(negedge clk);
        chk("rst_rd_psr", int'(psr), 0);
        chk("rst_rd_busy", int'(busy), 0);
        chk("rst_rd_hold", int'(hold), 0);
        srst = 0;
        job_over = 1;
        for (int n = 0; n < 100 && feeding; n++) @(negedge clk);
        repeat (40) @(negedge clk);

        // random jobs against the reference model
        for (int j = 0; j < 10; j++) begin
            adr = $urandom_range(0, 32767);
            cnt = $urandom_range(1, 6);
            ver = 1'($urandom_range(0, 1));
            fat = $urandom_range(0, 1) ? $urandom_range(0, cnt - 1) : -1;
            fn  = $urandom_range(0, 3);
            lat = $urandom_range(1, 12);
            gap = $urandom_range(0, 3);
            model(adr, cnt, ver, fat, fn);
            run_job(adr, cnt, ver, fat, fn, lat, -1, gap, 1);
            chk("rnd_done", r_done, 1);
            chk("rnd_err", r_err, m_err);
            chk("rnd_err_adr", r_eadr, m_eadr);
            chk("rnd_left", r_left, m_left);
            chk_seq();
            if (m_err == 0) chk("rnd_accepted", n_acc, cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
